normalizador_pipe: RTL
======================

Name: normalizador_pipe

Overview:
- Pipelined, parametrised fixed-point normaliser: multiplies a signed fixed-point input by a runtime-programmable coefficient and repacks the product into the estimator word (sign : pad : integer : fraction).
- Sits between the fixed-point datapath and the estimator input.
- Adds valid/ready flow control, a coefficient register, overflow detection and an overflow counter.

Parameters:
- W, 32, input, coefficient and output word width.
- FA, 26, fraction bits of input and coefficient (1.0 = 2^FA).
- PAD, 3, zero pad bits between the output sign and the integer field.
- INT_OUT, 5, integer bits in the output field.
- FRAC_OUT, 23, fraction bits in the output field. Requires 1+PAD+INT_OUT+FRAC_OUT == W.
- K_RST, 32'h0400_0000, coefficient reset value (1.0).
- CNT_W, 16, overflow counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- k_load  in  1  load coefficient this cycle
- k_in  in  W  new coefficient, signed Q(W-1-FA).FA
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- a_in  in  W  signed Q(W-1-FA).FA input
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- y_out  out  W  packed result
- ovf  out  1  overflow flag, aligned with y_out
- ovf_cnt  out  CNT_W  saturating count of overflowed outputs
- ovf_clr  in  1  synchronous clear of ovf_cnt

Behaviour:
- Reset: all stage valids 0, out_valid=0, y_out=0, ovf=0, ovf_cnt=0, coefficient=K_RST.
- Pipeline: 3 stages, latency 3 cycles from input handshake to out_valid with no stall.
  - S1 registers a_in and the current coefficient.
  - S2 registers the signed 2W-bit product P.
  - S3 packs, detects overflow and registers.
- Flow control: adv = ~out_valid | out_ready. All stages shift only when adv; in_ready = adv (combinational). Input is accepted when in_valid & in_ready.
- Bubbles: a bubble stage carries valid=0. No data is lost or duplicated under any out_ready pattern.
- Full throughput: 1 word/cycle while out_ready is held high.
- Coefficient:
  - k_load writes the coefficient register regardless of stall.
  - A word captured in S1 on the same edge as k_load uses the OLD coefficient; words accepted afterwards use the new one.
  - In-flight words keep the coefficient they captured.
- Pack: sign = P[2W-1]; field = P[2FA+INT_OUT-1 : 2FA-FRAC_OUT]; y = {sign, PAD zeros, field}. Low fraction bits are truncated.
- Overflow: ovf=1 when any bit of P[2W-2 : 2FA+INT_OUT] differs from P[2W-1].
- ovf_cnt:
  - Increments on each output handshake (out_valid & out_ready) with ovf=1.
  - Saturates at all-ones.
  - ovf_clr has priority over an increment in the same cycle.
- Reset mid-operation: all in-flight words are discarded; out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: NORM_SAT_EN.
- Defined: on overflow, field is clamped to all-ones when sign=0 and to all-zeros when sign=1; the pad bits remain 0.
- Not defined: the field is the raw truncated bits.
- ovf and ovf_cnt behave identically in both builds.

Decomposition:
- Shared package norm_pkg:
  - Default constants K_ONE (1.0 at FA=26) and the W/FA/PAD/INT_OUT/FRAC_OUT defaults.
  - A pack-width check function.
- One sub-module, norm_pack: combinational extract, overflow detection and optional saturation. Instanced in S3.
- The multiplier is inferred in S2.

Test Plan:
- After reset, a_in=32'h0400_0000 (1.0), K=1.0, out_ready=1 -> three cycles later y_out=32'h0080_0000, ovf=0.
- a_in=2.5 (32'h0A00_0000), k_load 0.5 (32'h0200_0000) in the same cycle as the input, then a second 2.5 -> first result 2.5 (32'h0140_0000), second 1.25 (32'h00A0_0000).
- a_in=31.0, K=2.0 -> ovf=1, ovf_cnt=1. With NORM_SAT_EN: y_out=32'h0FFF_FFFF. Without: y_out=32'h0F00_0000 (raw field for 62.0).
- Stream of 10 words while out_ready toggles 1,0,0,1,... -> all 10 outputs arrive in order with no loss, and in_ready equals adv in every cycle.
- Hold ovf_cnt at 16'hFFFF, then inject an overflow -> ovf_cnt stays 16'hFFFF. Assert ovf_clr together with an overflow handshake -> ovf_cnt=0.
- Assert rst with 3 words in flight -> out_valid=0 immediately; after release, no stale word is ever emitted.

Source files
------------

// File: rtl/normalizador_pipe_pkg.sv
// Shared defaults and elaboration helpers for the normalizador_pipe slice.
// NORM_SAT_EN (see norm_pack) selects saturating repack on overflow.
package norm_pkg;

  localparam int unsigned W_DEF        = 32;
  localparam int unsigned FA_DEF       = 26;
  localparam int unsigned PAD_DEF      = 3;
  localparam int unsigned INT_OUT_DEF  = 5;
  localparam int unsigned FRAC_OUT_DEF = 23;
  localparam int unsigned CNT_W_DEF    = 16;

  // 1.0 in Q5.26
  localparam logic [31:0] K_ONE = 32'h0400_0000;

  // Output word must tile exactly, and the extracted field must sit inside the product.
  function automatic bit pack_width_ok(input int unsigned w,
                                       input int unsigned fa,
                                       input int unsigned pad,
                                       input int unsigned int_out,
                                       input int unsigned frac_out);
    return (1 + pad + int_out + frac_out == w) &&
           (pad > 0) &&
           (2 * fa >= frac_out) &&
           (2 * fa + int_out <= 2 * w - 2);
  endfunction

endpackage

// File: rtl/normalizador_pipe_pack.sv
// Combinational repack of the 2W-bit product into {sign, pad, int, frac} with overflow flag.
// Build option NORM_SAT_EN clamps the field on overflow; otherwise the raw truncated bits pass.
module norm_pack
  import norm_pkg::*;
#(
  parameter int unsigned W        = W_DEF,
  parameter int unsigned FA       = FA_DEF,
  parameter int unsigned PAD      = PAD_DEF,
  parameter int unsigned INT_OUT  = INT_OUT_DEF,
  parameter int unsigned FRAC_OUT = FRAC_OUT_DEF
) (
  input  logic [2*W-1:0] p_i,
  output logic [W-1:0]   y_o,
  output logic           ovf_o
);

  localparam int unsigned FLD_W  = INT_OUT + FRAC_OUT;
  localparam int unsigned FLD_HI = 2 * FA + INT_OUT - 1;
  localparam int unsigned FLD_LO = 2 * FA - FRAC_OUT;
  localparam int unsigned HDR_LO = 2 * FA + INT_OUT;

  logic                 sign;
  logic [2*W-1:HDR_LO]  hdr;
  logic [FLD_W-1:0]     field;
  logic                 ovf;
  logic                 unused_lo;

  // Truncated fraction bits below the output LSB are intentionally dropped.
  assign unused_lo = ^p_i[FLD_LO-1:0];

  always_comb begin
    sign  = p_i[2*W-1];
    hdr   = p_i[2*W-1:HDR_LO];
    // Header bits (including the sign) must all agree for the value to fit.
    ovf   = ~((&hdr) | ~(|hdr));
    field = p_i[FLD_HI:FLD_LO];
`ifdef NORM_SAT_EN
    if (ovf) begin
      field = sign ? '0 : '1;
    end
`endif
    y_o   = {sign, {PAD{1'b0}}, field};
    ovf_o = ovf;
  end

endmodule

// File: rtl/normalizador_pipe.sv
// 3-stage fixed-point normaliser: capture, multiply by coefficient, repack with overflow count.
// Optional NORM_SAT_EN build saturates the repacked field on overflow (inside norm_pack).
module normalizador_pipe
  import norm_pkg::*;
#(
  parameter int unsigned     W        = W_DEF,
  parameter int unsigned     FA       = FA_DEF,
  parameter int unsigned     PAD      = PAD_DEF,
  parameter int unsigned     INT_OUT  = INT_OUT_DEF,
  parameter int unsigned     FRAC_OUT = FRAC_OUT_DEF,
  parameter logic [W-1:0]    K_RST    = W'(K_ONE),
  parameter int unsigned     CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             k_load,
  input  logic [W-1:0]     k_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y_out,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  if (!pack_width_ok(W, FA, PAD, INT_OUT, FRAC_OUT)) begin : g_bad_widths
    $error("normalizador_pipe: inconsistent output field widths");
  end

  logic               adv;
  logic [W-1:0]       k_q;
  logic               s1_v_q;
  logic [W-1:0]       s1_a_q;
  logic [W-1:0]       s1_k_q;
  logic               s2_v_q;
  logic [2*W-1:0]     s2_p_q;
  logic [2*W-1:0]     prod_d;
  logic               s3_v_q;
  logic [W-1:0]       y_q;
  logic [W-1:0]       y_d;
  logic               ovf_q;
  logic               ovf_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  // Whole pipe moves in lockstep; a stalled output freezes every stage.
  assign adv      = ~s3_v_q | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q <= K_RST;
    end else if (k_load) begin
      k_q <= k_in;
    end
  end

  // S1 samples k_q before any same-edge load lands, so that word keeps the old coefficient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      s1_k_q <= '0;
    end else if (adv) begin
      s1_v_q <= in_valid;
      s1_a_q <= a_in;
      s1_k_q <= k_q;
    end
  end

  // Low 2W bits of the sign-extended product equal the exact signed W x W product.
  always_comb begin
    prod_d = {{W{s1_a_q[W-1]}}, s1_a_q} * {{W{s1_k_q[W-1]}}, s1_k_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      s2_p_q <= '0;
    end else if (adv) begin
      s2_v_q <= s1_v_q;
      s2_p_q <= prod_d;
    end
  end

  norm_pack #(
    .W        (W),
    .FA       (FA),
    .PAD      (PAD),
    .INT_OUT  (INT_OUT),
    .FRAC_OUT (FRAC_OUT)
  ) u_pack (
    .p_i   (s2_p_q),
    .y_o   (y_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v_q <= 1'b0;
      y_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      s3_v_q <= s2_v_q;
      y_q    <= y_d;
      ovf_q  <= ovf_d & s2_v_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovf_clr) begin
      cnt_d = '0;
    end else if (s3_v_q && out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = s3_v_q;
  assign y_out     = y_q;
  assign ovf       = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule
